serializer: RTL and testbench
=============================

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter BYTES_PER_FRAME, default 4, number of payload bytes per frame (range 1..8).
REQ-002 SHALL have parameter GAP_BITS, default 2, number of forced-zero line cycles after each frame (range 1..15).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte buffer depth (power of 2, >= BYTES_PER_FRAME).
REQ-004 SHALL have port t_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port byte_in  input  8  payload byte offered by upstream.
REQ-007 SHALL have port byte_valid  input  1  byte_in valid this cycle.
REQ-008 SHALL have port byte_ready  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port data_out  output  1  registered serial line to the matching deserializer.
REQ-010 SHALL have port busy  output  1  frame in progress (header, payload or gap).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last payload bit on data_out.

Function
REQ-012 SHALL accept a byte on every rising edge where byte_valid and byte_ready are both 1; byte_ready = FIFO not full, no combinational dependence on byte_valid.
REQ-013 SHALL keep byte_ready high when the FIFO is full but a pop happens in the same cycle only if depth allows; baseline: byte_ready = !full (no pass-through).
REQ-014 SHALL support simultaneous push and pop in one cycle with occupancy unchanged.
REQ-015 SHALL use FSM states IDLE, HDR, DATA, GAP.
REQ-016 IDLE: data_out = 0; move to HDR when FIFO occupancy >= BYTES_PER_FRAME; partial frames are never started.
REQ-017 HDR: drive header 1,0,1,0 on four consecutive cycles, first bit on the cycle after the IDLE->HDR decision.
REQ-018 DATA: drive BYTES_PER_FRAME*8 bits, bytes in FIFO order, each byte MSB first, one bit per cycle, no gaps between bytes.
REQ-019 SHALL pop a byte from the FIFO when its first bit (MSB) is loaded into the shift register.
REQ-020 GAP: drive data_out = 0 for exactly GAP_BITS cycles, then IDLE; next header may start the cycle after GAP ends if occupancy allows.
REQ-021 Frame length on the line SHALL be exactly 4 + 8*BYTES_PER_FRAME + GAP_BITS cycles (default 38).
REQ-022 Bit counter SHALL be 3-bit within byte plus byte index of $clog2(BYTES_PER_FRAME)+1 bits; wrap to 0 at frame end.
REQ-023 busy SHALL be 1 in HDR, DATA and GAP, 0 in IDLE.
REQ-024 frame_done SHALL assert for exactly one cycle, aligned with the LSB of the final payload byte on data_out.
REQ-025 Upstream pushes during a frame SHALL be accepted while not full and SHALL not disturb the frame in flight.
REQ-026 byte_valid without byte_ready SHALL be ignored; no data lost or duplicated.

Reset
REQ-027 When rst_n = 0 at a rising edge: state = IDLE, FIFO empty, counters 0, data_out = 0, busy = 0, frame_done = 0, byte_ready = 1 on the following cycle.
REQ-028 Reset mid-frame SHALL abort the frame: data_out is 0 from the next edge, partial frame discarded, buffered bytes discarded.

Structure
REQ-029 Shared package serializer_pkg SHALL hold the state enum, HEADER constant 4'b1010, HDR_BITS = 4, and parameter defaults.
REQ-030 FIFO SHALL be a separate sub-module byte_fifo (synchronous, same clock/reset, push/pop/full/empty/count).
REQ-031 Shift register, counters and FSM SHALL live in serializer; total RTL 120-400 lines.

Verification
REQ-032 Push 8'hA5,8'h3C,8'hFF,8'h00 back-to-back -> line shows 1010 then 10100101 00111100 11111111 00000000, then 00, frame_done on bit 36, busy low after cycle 38.
REQ-033 Push only 3 bytes and wait 50 cycles -> data_out stays 0, busy 0; push 4th -> frame starts next cycle.
REQ-034 Push 8 bytes continuously with byte_valid held -> byte_ready drops at occupancy 4, two frames sent with exactly 2 zero cycles between headers.
REQ-035 Assert rst_n = 0 on payload bit 10 -> data_out 0 next edge, FIFO empty, no frame_done, byte_ready 1.
REQ-036 Loopback into the deserializer with random bytes over 100 frames -> every received byte equals the transmitted byte, in order.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Frame on the line: 4-bit header, BYTES_PER_FRAME bytes MSB first, then forced-zero gap.
package serializer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StGap
    } ser_state_e;

    localparam logic [3:0]  HEADER   = 4'b1010;
    localparam int unsigned HDR_BITS = 4;

    localparam int unsigned DefBytesPerFrame = 4;
    localparam int unsigned DefGapBits       = 2;
    localparam int unsigned DefFifoDepth     = 4;

    // Header is sent MSB first; idx 0 is the first bit on the line.
    function automatic logic header_bit(input logic [1:0] idx);
        return HEADER[2'd3 - idx];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count; no pass-through when full.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            pop_i,
    output logic [7:0]      data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/serializer.sv
// Framed byte-to-bit serializer: buffers bytes, then sends header, payload and gap.
// state_q names the phase of the bit currently on data_out; next-state logic picks the next bit.
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned BYTES_PER_FRAME = DefBytesPerFrame,
    parameter int unsigned GAP_BITS        = DefGapBits,
    parameter int unsigned FIFO_DEPTH      = DefFifoDepth
) (
    input  logic       t_clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       data_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned ByteIdxW = $clog2(BYTES_PER_FRAME) + 1;
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);

    ser_state_e          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                data_out_q, data_out_d;
    logic                frame_done_q, frame_done_d;

    logic [7:0]      fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            push, pop;
    logic            frame_ready, last_byte;

    assign byte_ready  = ~fifo_full;
    assign push        = byte_valid & ~fifo_full;
    assign frame_ready = (fifo_count >= CntW'(BYTES_PER_FRAME));
    assign last_byte   = (byte_idx_q == ByteIdxW'(BYTES_PER_FRAME - 1));

    byte_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (t_clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (byte_in),
        .pop_i   (pop & ~fifo_empty),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        gap_cnt_d    = gap_cnt_q;
        shift_d      = shift_q;
        data_out_d   = 1'b0;
        frame_done_d = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_ready) begin
                    state_d    = StHdr;
                    bit_cnt_d  = '0;
                    data_out_d = header_bit(2'd0);
                end
            end

            StHdr: begin
                if (bit_cnt_q == 3'(HDR_BITS - 1)) begin
                    // Byte leaves the FIFO on the same edge its MSB reaches the line.
                    state_d    = StData;
                    pop        = 1'b1;
                    data_out_d = fifo_rdata[7];
                    shift_d    = {fifo_rdata[6:0], 1'b0};
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    data_out_d = header_bit(bit_cnt_q[1:0] + 2'd1);
                end
            end

            StData: begin
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d = '0;
                    if (last_byte) begin
                        state_d    = StGap;
                        byte_idx_d = '0;
                        gap_cnt_d  = '0;
                    end else begin
                        pop        = 1'b1;
                        data_out_d = fifo_rdata[7];
                        shift_d    = {fifo_rdata[6:0], 1'b0};
                        byte_idx_d = byte_idx_q + ByteIdxW'(1);
                    end
                end else begin
                    data_out_d   = shift_q[7];
                    shift_d      = {shift_q[6:0], 1'b0};
                    bit_cnt_d    = bit_cnt_q + 3'd1;
                    frame_done_d = last_byte && (bit_cnt_q == 3'd6);
                end
            end

            StGap: begin
                if (gap_cnt_q == 4'(GAP_BITS - 1)) begin
                    gap_cnt_d = '0;
                    // Chain straight into the next header when a full frame is waiting.
                    if (frame_ready) begin
                        state_d    = StHdr;
                        bit_cnt_d  = '0;
                        data_out_d = header_bit(2'd0);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            gap_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: frame-level queue model, line decoder and directed literal checks.
module tb_serializer;

    localparam int BPF       = 4;
    localparam int GAP       = 2;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 4 + 8 * BPF + GAP;

    logic       t_clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       data_out;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    serializer #(
        .BYTES_PER_FRAME (BPF),
        .GAP_BITS        (GAP),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .t_clk      (t_clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 t_clk = ~t_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic line_bit;
        logic done;
        logic pop;
    } rec_t;

    logic [7:0] m_fifo [$];
    logic [7:0] sent_q [$];
    rec_t       line_q [$];
    logic       exp_data, exp_busy, exp_done, exp_ready;
    logic       chk_en = 1'b0;
    int         done_cnt = 0;

    task automatic build_frame();
        logic [3:0] hdr = 4'b1010;
        rec_t r;
        for (int h = 3; h >= 0; h--) begin
            r = '{line_bit: hdr[h], done: 1'b0, pop: 1'b0};
            line_q.push_back(r);
        end
        for (int k = 0; k < BPF; k++) begin
            for (int b = 7; b >= 0; b--) begin
                r = '{line_bit: m_fifo[k][b], done: (k == BPF - 1) && (b == 0), pop: (b == 7)};
                line_q.push_back(r);
            end
        end
        for (int g = 0; g < GAP; g++) begin
            r = '{line_bit: 1'b0, done: 1'b0, pop: 1'b0};
            line_q.push_back(r);
        end
    endtask

    initial forever begin
        logic acc;
        logic [7:0] tmp;
        rec_t r;
        @(posedge t_clk);
        if (!rst_n) begin
            m_fifo.delete();
            line_q.delete();
            sent_q.delete();
            exp_data  = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end else begin
            acc = byte_valid && (m_fifo.size() < DEPTH);
            if (line_q.size() == 0 && m_fifo.size() >= BPF) build_frame();
            if (line_q.size() != 0) begin
                r = line_q.pop_front();
                exp_data = r.line_bit;
                exp_busy = 1'b1;
                exp_done = r.done;
                if (r.pop) tmp = m_fifo.pop_front();
            end else begin
                exp_data = 1'b0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end
            if (acc) begin
                m_fifo.push_back(byte_in);
                sent_q.push_back(byte_in);
            end
            exp_ready = (m_fifo.size() < DEPTH);
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge t_clk);
        if (frame_done === 1'b1) done_cnt++;
        if (chk_en) begin
            check("data_out", 64'(data_out), 64'(exp_data));
            check("busy", 64'(busy), 64'(exp_busy));
            check("frame_done", 64'(frame_done), 64'(exp_done));
            check("byte_ready", 64'(byte_ready), 64'(exp_ready));
        end
    end

    // Line decoder: recovers payload bytes and checks them against accepted bytes in order.
    initial forever begin
        int d_idx;
        logic [7:0] d_sh;
        logic [3:0] hdr;
        hdr = 4'b1010;
        d_idx = 0;
        d_sh = '0;
        forever begin
            @(negedge t_clk);
            if (chk_en && busy === 1'b1) begin
                if (d_idx < 4) begin
                    check("rx_hdr", 64'(data_out), 64'(hdr[3 - d_idx]));
                end else if (d_idx < 4 + 8 * BPF) begin
                    d_sh = {d_sh[6:0], data_out};
                    if ((d_idx - 4) % 8 == 7) begin
                        if (sent_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_byte: got %0h expected none", d_sh);
                        end else begin
                            check("rx_byte", 64'(d_sh), 64'(sent_q.pop_front()));
                        end
                    end
                end else begin
                    check("rx_gap", 64'(data_out), 64'd0);
                end
                d_idx = (d_idx == FRAME_LEN - 1) ? 0 : d_idx + 1;
            end else begin
                d_idx = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge t_clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 300) begin
            @(negedge t_clk);
            guard++;
        end
        if (guard >= 300) timeout("push_wait");
    endtask

    task automatic wait_busy(input string name);
        int w;
        w = 0;
        while (!busy && w < 60) begin
            @(negedge t_clk);
            w++;
        end
        if (!busy) timeout(name);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        repeat (3) @(negedge t_clk);
        while (busy && g < 500) begin
            @(negedge t_clk);
            g++;
        end
        if (busy) timeout("wait_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] cap;
        logic [7:0]  t3 [8];
        int          done_at;
        int          run;
        int          done_before;

        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        repeat (3) @(negedge t_clk);
        chk_en = 1'b1;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_byte_ready", 64'(byte_ready), 64'd1);
        rst_n = 1'b1;

        // Test 1: one known frame captured bit by bit.
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        push_byte(8'h00);
        @(negedge t_clk);
        byte_valid = 1'b0;
        wait_busy("t1_start");
        done_at = -1;
        for (int i = 0; i < 38; i++) begin
            cap[37 - i] = data_out;
            if (frame_done) done_at = i;
            if (i < 37) @(negedge t_clk);
        end
        check("t1_line", 64'(cap), 64'(38'b1010_10100101_00111100_11111111_00000000_00));
        check("t1_done_pos", 64'(done_at), 64'd35);
        @(negedge t_clk);
        check("t1_busy_after", 64'(busy), 64'd0);
        wait_idle();

        // Test 2: partial frame never starts; fourth byte triggers it.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        @(negedge t_clk);
        byte_valid = 1'b0;
        repeat (50) @(negedge t_clk);
        check("t2_partial_busy", 64'(busy), 64'd0);
        check("t2_partial_line", 64'(data_out), 64'd0);
        push_byte(8'h44);
        @(negedge t_clk);
        byte_valid = 1'b0;
        check("t2_decide_cycle", 64'(busy), 64'd0);
        @(negedge t_clk);
        check("t2_hdr_busy", 64'(busy), 64'd1);
        check("t2_hdr_bit", 64'(data_out), 64'd1);
        wait_idle();

        // Test 3: eight bytes with valid held; two frames back to back.
        t3 = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hF0, 8'h0F, 8'hC3, 8'h99};
        fork
            begin
                for (int i = 0; i < 8; i++) push_byte(t3[i]);
                @(negedge t_clk);
                byte_valid = 1'b0;
            end
            begin
                wait_busy("t3_start");
                run = 0;
                while (busy && run < 300) begin
                    @(negedge t_clk);
                    run++;
                end
                check("t3_busy_run", 64'(run), 64'(2 * FRAME_LEN));
            end
        join
        wait_idle();

        // Test 4: reset on payload bit 10 aborts the frame.
        push_byte(8'h5A);
        push_byte(8'hC3);
        push_byte(8'h81);
        push_byte(8'h7E);
        @(negedge t_clk);
        byte_valid = 1'b0;
        wait_busy("t4_start");
        repeat (13) @(negedge t_clk);
        rst_n = 1'b0;
        done_before = done_cnt;
        @(negedge t_clk);
        check("t4_rst_data_out", 64'(data_out), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_byte_ready", 64'(byte_ready), 64'd1);
        rst_n = 1'b1;
        repeat (50) @(negedge t_clk);
        check("t4_no_restart", 64'(busy), 64'd0);
        check("t4_no_done", 64'(done_cnt), 64'(done_before));

        // Test 5: 100 frames of random bytes with random idle gaps.
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < BPF; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge t_clk);
                    byte_valid = 1'b0;
                end
                push_byte(8'($urandom));
            end
        end
        @(negedge t_clk);
        byte_valid = 1'b0;
        wait_idle();
        check("t5_all_received", 64'(sent_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
